butterfly2_stream: RTL and testbench
====================================

// Module: butterfly2_stream
// PURPOSE
//  Pipelined, parametrised radix-2 DIT butterfly with valid/ready streaming:
//  out0 = in0 + in1*W, out1 = in0 - in1*W, W optionally conjugated (IFFT).
//  Per-sample 1/2 scaling, rounding and saturation are selectable.
//  Sits between the twiddle ROM / stage buffer and the next FFT stage.
//  Supports the backpressure that multi-stage FFT schedulers need.
// PARAMETERS
//  N      16  data/twiddle width, signed two's complement
//  Q      8   fractional bits of data and twiddle (1.0 = 2^Q); 1 <= Q <= N-2
//  ROUND  1   1: round-half-up at final shift; 0: truncate (floor)
// PORTS
//  i_clk           in   1  clock, rising edge
//  i_rst           in   1  asynchronous reset, active-low
//  i_valid         in   1  input sample valid
//  o_ready         out  1  block can accept input this cycle
//  i_in0_re/_im    in   N  complex operand in0
//  i_in1_re/_im    in   N  complex operand in1
//  i_twiddle_re/_im in  N  twiddle W^nk
//  i_inverse       in   1  1: use conj(W) (twiddle_im negated); sampled with data
//  i_scale         in   1  1: outputs divided by 2 (extra shift); sampled with data
//  o_valid         out  1  output sample valid
//  i_out_ready     in   1  downstream accepts output this cycle
//  o_out0_re/_im   out  N  in0 + in1*W
//  o_out1_re/_im   out  N  in0 - in1*W
//  o_sat           out  1  any of the 4 outputs of current o_valid sample clipped
//  o_sat_sticky    out  1  set on any clipped sample transferred; cleared by i_clr_sat
//  i_clr_sat       in   1  synchronous clear of o_sat_sticky (wins over same-cycle set)
// BEHAVIOUR
//  - Reset (i_rst=0, async): all pipeline valids, o_valid, o_sat, o_sat_sticky,
//    all data outputs = 0. Reset mid-stream discards every in-flight sample.
//  - Pipeline enable ce = ~o_valid | i_out_ready; o_ready = ce (combinational).
//    Transfer in: i_valid & o_ready. Transfer out: o_valid & i_out_ready.
//  - All 3 stages advance together when ce=1; hold all state when ce=0.
//    Bubbles (valid=0) propagate; no reordering, no loss, no duplication.
//  - Latency: exactly 3 enabled cycles from input transfer to o_valid.
//    Throughput 1 sample/cycle while i_out_ready=1.
//  - S1: register operands, i_inverse, i_scale; w_im_eff = inverse ? -w_im : w_im,
//    computed at N+1 bits (negating -2^(N-1) must not wrap).
//  - S2: four signed products, full width; p_re = a_re*w_re - a_im*w_im_eff,
//    p_im = a_re*w_im_eff + a_im*w_re, kept at 2N+2 bits (no truncation).
//  - S3: s0 = (in0<<Q) + p, s1 = (in0<<Q) - p per component, 2N+3 bits.
//    sh = Q + scale. ROUND=1: add 2^(sh-1) before arithmetic >> sh; ROUND=0: plain >>.
//    Saturate to [-2^(N-1), 2^(N-1)-1]; o_sat = OR of four clip flags, registered
//    with the sample.
//  - o_sat valid only when o_valid=1, else 0. o_sat_sticky sets on output transfer
//    with o_sat=1.
//  - Data outputs hold last value while o_valid=0 or stalled; must be stable while
//    o_valid & ~i_out_ready.
//  - i_valid with o_ready=0: no transfer; upstream holds data (no capture).
// TESTING (N=16, Q=8, ROUND=1; 1.0 = 256)
//  1 in0=(256,0) in1=(256,0) W=(256,0) -> 3 cycles later out0=(512,0) out1=(0,0),
//    o_sat=0.
//  2 in0=(0,0) in1=(256,0) W=(0,256) -> out0=(0,256) out1=(0,-256);
//    same with i_inverse=1 -> out0=(0,-256) out1=(0,256).
//  3 in0=(32767,0) in1=(32767,0) W=(256,0) -> out0_re=32767 clipped, out1_re=0,
//    o_sat=1, o_sat_sticky=1 until i_clr_sat.
//  4 in0=(3,0) in1=0 W=(256,0) i_scale=1 -> out0=out1=(2,0) (1.5 rounds up);
//    ROUND=0 build -> (1,0).
//  5 stream 16 distinct samples, i_out_ready=0 for cycles 4-9 and random
//    thereafter -> all 16 out in order, none dropped/duplicated, outputs stable
//    during stall.
//  6 i_rst low for 1 cycle with 2 samples in flight -> o_valid=0 next edge, those
//    samples never appear, new input accepted after release.

Source files
------------

// File: rtl/butterfly2_stream.sv
// Pipelined radix-2 DIT butterfly: out0 = in0 + in1*W, out1 = in0 - in1*W.
// Three-stage valid/ready pipeline with optional conj(W), 1/2 scaling, rounding and saturation.
module butterfly2_stream #(
  parameter int N     = 16,
  parameter int Q     = 8,
  parameter int ROUND = 1
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_valid,
  output logic                o_ready,
  input  logic signed [N-1:0] i_in0_re,
  input  logic signed [N-1:0] i_in0_im,
  input  logic signed [N-1:0] i_in1_re,
  input  logic signed [N-1:0] i_in1_im,
  input  logic signed [N-1:0] i_twiddle_re,
  input  logic signed [N-1:0] i_twiddle_im,
  input  logic                i_inverse,
  input  logic                i_scale,
  output logic                o_valid,
  input  logic                i_out_ready,
  output logic signed [N-1:0] o_out0_re,
  output logic signed [N-1:0] o_out0_im,
  output logic signed [N-1:0] o_out1_re,
  output logic signed [N-1:0] o_out1_im,
  output logic                o_sat,
  output logic                o_sat_sticky,
  input  logic                i_clr_sat
);

  localparam int PW = 2*N + 2;
  localparam int SW = 2*N + 3;
  localparam logic signed [SW-1:0] SAT_MAX = {{(SW-N+1){1'b0}}, {(N-1){1'b1}}};
  localparam logic signed [SW-1:0] SAT_MIN = {{(SW-N+1){1'b1}}, {(N-1){1'b0}}};

  logic                 ce;
  logic                 v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
  logic signed [N-1:0]  a0_re1_q, a0_re1_d, a0_im1_q, a0_im1_d;
  logic signed [N-1:0]  a1_re1_q, a1_re1_d, a1_im1_q, a1_im1_d;
  logic signed [N-1:0]  w_re1_q, w_re1_d;
  logic signed [N:0]    w_im1_q, w_im1_d;
  logic                 sc1_q, sc1_d, sc2_q, sc2_d;
  logic signed [N-1:0]  a0_re2_q, a0_re2_d, a0_im2_q, a0_im2_d;
  logic signed [PW-1:0] p_re2_q, p_re2_d, p_im2_q, p_im2_d;
  logic signed [N-1:0]  o0_re_q, o0_re_d, o0_im_q, o0_im_d;
  logic signed [N-1:0]  o1_re_q, o1_re_d, o1_im_q, o1_im_d;
  logic                 sat_q, sat_d, sticky_q, sticky_d;

  logic signed [N:0]    w_im_ext;
  logic signed [PW-1:0] ar, ai, wr, wi;
  logic signed [SW-1:0] x_re, x_im, pr, pi;
  logic [N:0]           r0_re, r0_im, r1_re, r1_im;

  // Returns {clip, value}: optional half-up rounding, shift by Q (+1 when scaling), clamp.
  function automatic logic [N:0] scale_sat(input logic signed [SW-1:0] s, input logic sc);
    logic signed [SW-1:0] r;
    r = s;
    if (ROUND != 0) r = r + (sc ? (SW'(1) <<< Q) : (SW'(1) <<< (Q-1)));
    r = sc ? (r >>> (Q+1)) : (r >>> Q);
    if (r > SAT_MAX) return {1'b1, SAT_MAX[N-1:0]};
    if (r < SAT_MIN) return {1'b1, SAT_MIN[N-1:0]};
    return {1'b0, r[N-1:0]};
  endfunction

  always_comb begin
    ce = ~v3_q | i_out_ready;

    v1_d = v1_q;  v2_d = v2_q;  v3_d = v3_q;
    a0_re1_d = a0_re1_q;  a0_im1_d = a0_im1_q;
    a1_re1_d = a1_re1_q;  a1_im1_d = a1_im1_q;
    w_re1_d  = w_re1_q;   w_im1_d  = w_im1_q;
    sc1_d = sc1_q;  sc2_d = sc2_q;
    a0_re2_d = a0_re2_q;  a0_im2_d = a0_im2_q;
    p_re2_d  = p_re2_q;   p_im2_d  = p_im2_q;
    o0_re_d = o0_re_q;  o0_im_d = o0_im_q;
    o1_re_d = o1_re_q;  o1_im_d = o1_im_q;
    sat_d = sat_q;

    // N+1 bits so that conjugating a twiddle of -2^(N-1) stays positive
    w_im_ext = {i_twiddle_im[N-1], i_twiddle_im};

    ar = PW'(a1_re1_q);
    ai = PW'(a1_im1_q);
    wr = PW'(w_re1_q);
    wi = PW'(w_im1_q);

    x_re = SW'(a0_re2_q) <<< Q;
    x_im = SW'(a0_im2_q) <<< Q;
    pr   = SW'(p_re2_q);
    pi   = SW'(p_im2_q);
    r0_re = scale_sat(x_re + pr, sc2_q);
    r0_im = scale_sat(x_im + pi, sc2_q);
    r1_re = scale_sat(x_re - pr, sc2_q);
    r1_im = scale_sat(x_im - pi, sc2_q);

    if (ce) begin
      v1_d = i_valid;
      if (i_valid) begin
        a0_re1_d = i_in0_re;  a0_im1_d = i_in0_im;
        a1_re1_d = i_in1_re;  a1_im1_d = i_in1_im;
        w_re1_d  = i_twiddle_re;
        w_im1_d  = i_inverse ? -w_im_ext : w_im_ext;
        sc1_d    = i_scale;
      end
      v2_d = v1_q;
      if (v1_q) begin
        a0_re2_d = a0_re1_q;  a0_im2_d = a0_im1_q;
        p_re2_d  = ar * wr - ai * wi;
        p_im2_d  = ar * wi + ai * wr;
        sc2_d    = sc1_q;
      end
      v3_d  = v2_q;
      sat_d = 1'b0;
      if (v2_q) begin
        o0_re_d = r0_re[N-1:0];  o0_im_d = r0_im[N-1:0];
        o1_re_d = r1_re[N-1:0];  o1_im_d = r1_im[N-1:0];
        sat_d   = r0_re[N] | r0_im[N] | r1_re[N] | r1_im[N];
      end
    end

    sticky_d = i_clr_sat ? 1'b0 : (sticky_q | (v3_q & i_out_ready & sat_q));
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      v1_q <= 1'b0;  v2_q <= 1'b0;  v3_q <= 1'b0;
      a0_re1_q <= '0;  a0_im1_q <= '0;  a1_re1_q <= '0;  a1_im1_q <= '0;
      w_re1_q  <= '0;  w_im1_q  <= '0;  sc1_q <= 1'b0;  sc2_q <= 1'b0;
      a0_re2_q <= '0;  a0_im2_q <= '0;  p_re2_q <= '0;  p_im2_q <= '0;
      o0_re_q <= '0;  o0_im_q <= '0;  o1_re_q <= '0;  o1_im_q <= '0;
      sat_q <= 1'b0;  sticky_q <= 1'b0;
    end else begin
      v1_q <= v1_d;  v2_q <= v2_d;  v3_q <= v3_d;
      a0_re1_q <= a0_re1_d;  a0_im1_q <= a0_im1_d;
      a1_re1_q <= a1_re1_d;  a1_im1_q <= a1_im1_d;
      w_re1_q  <= w_re1_d;   w_im1_q  <= w_im1_d;
      sc1_q <= sc1_d;  sc2_q <= sc2_d;
      a0_re2_q <= a0_re2_d;  a0_im2_q <= a0_im2_d;
      p_re2_q  <= p_re2_d;   p_im2_q  <= p_im2_d;
      o0_re_q <= o0_re_d;  o0_im_q <= o0_im_d;
      o1_re_q <= o1_re_d;  o1_im_q <= o1_im_d;
      sat_q <= sat_d;  sticky_q <= sticky_d;
    end
  end

  assign o_ready      = ce;
  assign o_valid      = v3_q;
  assign o_out0_re    = o0_re_q;
  assign o_out0_im    = o0_im_q;
  assign o_out1_re    = o1_re_q;
  assign o_out1_im    = o1_im_q;
  assign o_sat        = sat_q;
  assign o_sat_sticky = sticky_q;

endmodule

// File: tb/tb_butterfly2_stream.sv
// Directed bench for butterfly2_stream: arithmetic vectors, rounding modes, saturation,
// sticky flag, backpressured streaming and mid-stream reset.
module tb_butterfly2_stream;
  localparam int N = 16;

  logic i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  logic i_rst, i_valid, i_inverse, i_scale, i_out_ready, i_clr_sat;
  logic signed [N-1:0] i_in0_re, i_in0_im, i_in1_re, i_in1_im, i_twiddle_re, i_twiddle_im;
  logic o_ready, o_valid, o_sat, o_sat_sticky;
  logic signed [N-1:0] o_out0_re, o_out0_im, o_out1_re, o_out1_im;
  logic t_ready, t_valid, t_sat, t_sat_sticky;
  logic signed [N-1:0] t_out0_re, t_out0_im, t_out1_re, t_out1_im;

  butterfly2_stream #(.N(N), .Q(8), .ROUND(1)) u_dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready),
    .i_in0_re(i_in0_re), .i_in0_im(i_in0_im), .i_in1_re(i_in1_re), .i_in1_im(i_in1_im),
    .i_twiddle_re(i_twiddle_re), .i_twiddle_im(i_twiddle_im),
    .i_inverse(i_inverse), .i_scale(i_scale), .o_valid(o_valid), .i_out_ready(i_out_ready),
    .o_out0_re(o_out0_re), .o_out0_im(o_out0_im), .o_out1_re(o_out1_re), .o_out1_im(o_out1_im),
    .o_sat(o_sat), .o_sat_sticky(o_sat_sticky), .i_clr_sat(i_clr_sat)
  );

  butterfly2_stream #(.N(N), .Q(8), .ROUND(0)) u_trunc (
    .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(t_ready),
    .i_in0_re(i_in0_re), .i_in0_im(i_in0_im), .i_in1_re(i_in1_re), .i_in1_im(i_in1_im),
    .i_twiddle_re(i_twiddle_re), .i_twiddle_im(i_twiddle_im),
    .i_inverse(i_inverse), .i_scale(i_scale), .o_valid(t_valid), .i_out_ready(i_out_ready),
    .o_out0_re(t_out0_re), .o_out0_im(t_out0_im), .o_out1_re(t_out1_re), .o_out1_im(t_out1_im),
    .o_sat(t_sat), .o_sat_sticky(t_sat_sticky), .i_clr_sat(i_clr_sat)
  );

  int o0r, o0i, o1r, o1i, ov, ordy, osat, ostk, t0r, t1r;
  assign o0r  = int'(o_out0_re);
  assign o0i  = int'(o_out0_im);
  assign o1r  = int'(o_out1_re);
  assign o1i  = int'(o_out1_im);
  assign ov   = int'(o_valid);
  assign ordy = int'(o_ready);
  assign osat = int'(o_sat);
  assign ostk = int'(o_sat_sticky);
  assign t0r  = int'(t_out0_re);
  assign t1r  = int'(t_out1_re);

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic check4(input string tag, input int g0r, input int g0i, input int g1r,
                        input int g1i, input int e0r, input int e0i, input int e1r, input int e1i);
    check({tag, "_o0re"}, g0r, e0r);
    check({tag, "_o0im"}, g0i, e0i);
    check({tag, "_o1re"}, g1r, e1r);
    check({tag, "_o1im"}, g1i, e1i);
  endtask

  task automatic drive(input int a0r, input int a0i, input int a1r, input int a1i,
                       input int wr, input int wi, input bit inv, input bit sc);
    i_in0_re = 16'(a0r);  i_in0_im = 16'(a0i);
    i_in1_re = 16'(a1r);  i_in1_im = 16'(a1i);
    i_twiddle_re = 16'(wr);  i_twiddle_im = 16'(wi);
    i_inverse = inv;  i_scale = sc;
  endtask

  // One sample through an idle pipeline; also pins the 3-cycle latency.
  task automatic send_one(input string tag, input int a0r, input int a0i, input int a1r,
                          input int a1i, input int wr, input int wi, input bit inv, input bit sc);
    drive(a0r, a0i, a1r, a1i, wr, wi, inv, sc);
    i_valid = 1'b1;
    i_out_ready = 1'b1;
    @(posedge i_clk); #1;
    i_valid = 1'b0;
    @(posedge i_clk); #1;
    check({tag, "_lat_early"}, ov, 0);
    @(posedge i_clk); #1;
    check({tag, "_lat_valid"}, ov, 1);
  endtask

  int sent, recv, h0r, h0i, h1r, h1i, hrdy;
  bit in_x, out_x, stall;

  initial begin
    i_rst = 1'b0;  i_valid = 1'b0;  i_out_ready = 1'b1;  i_clr_sat = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 1'b0, 1'b0);
    #12;
    check("rst_valid", ov, 0);
    check("rst_sat", osat, 0);
    check("rst_sticky", ostk, 0);
    check4("rst", o0r, o0i, o1r, o1i, 0, 0, 0, 0);
    check("rst_ready", ordy, 1);
    @(negedge i_clk);
    i_rst = 1'b1;
    @(posedge i_clk); #1;

    send_one("t1", 256, 0, 256, 0, 256, 0, 1'b0, 1'b0);
    check4("t1", o0r, o0i, o1r, o1i, 512, 0, 0, 0);
    check("t1_sat", osat, 0);
    @(posedge i_clk); #1;
    check("t1_bubble_valid", ov, 0);
    check4("t1_hold", o0r, o0i, o1r, o1i, 512, 0, 0, 0);

    send_one("t2", 0, 0, 256, 0, 0, 256, 1'b0, 1'b0);
    check4("t2", o0r, o0i, o1r, o1i, 0, 256, 0, -256);
    send_one("t2i", 0, 0, 256, 0, 0, 256, 1'b1, 1'b0);
    check4("t2i", o0r, o0i, o1r, o1i, 0, -256, 0, 256);
    send_one("wmin", 0, 0, 0, 1, 0, -32768, 1'b1, 1'b0);
    check4("wmin", o0r, o0i, o1r, o1i, -128, 0, 128, 0);

    send_one("t3", 32767, 0, 32767, 0, 256, 0, 1'b0, 1'b0);
    check4("t3", o0r, o0i, o1r, o1i, 32767, 0, 0, 0);
    check("t3_sat", osat, 1);
    @(posedge i_clk); #1;
    check("t3_sticky_set", ostk, 1);
    check("t3_sat_novalid", osat, 0);
    @(posedge i_clk); #1;
    check("t3_sticky_keep", ostk, 1);
    i_clr_sat = 1'b1;
    @(posedge i_clk); #1;
    i_clr_sat = 1'b0;
    check("t3_sticky_clr", ostk, 0);

    send_one("nsat", -32768, 0, -32768, 0, 256, 0, 1'b0, 1'b0);
    check4("nsat", o0r, o0i, o1r, o1i, -32768, 0, 0, 0);
    check("nsat_sat", osat, 1);
    i_clr_sat = 1'b1;
    @(posedge i_clk); #1;
    i_clr_sat = 1'b0;
    check("clr_wins", ostk, 0);

    send_one("t4", 3, 0, 0, 0, 256, 0, 1'b0, 1'b1);
    check4("t4", o0r, o0i, o1r, o1i, 2, 0, 2, 0);
    check("t4_trunc0", t0r, 1);
    check("t4_trunc1", t1r, 1);
    send_one("neg", -3, 0, 0, 0, 256, 0, 1'b0, 1'b1);
    check("neg_rnd", o0r, -1);
    check("neg_trunc", t0r, -2);
    send_one("half", 0, 0, 1, 0, 128, 0, 1'b0, 1'b0);
    check("half_rnd0", o0r, 1);
    check("half_rnd1", o1r, 0);
    check("half_trunc0", t0r, 0);
    check("half_trunc1", t1r, -1);

    // Stream 16 samples with W=1.0: out0 = (100+11k, 2k), out1 = (100-9k, -4k).
    @(posedge i_clk); #1;
    sent = 0;
    recv = 0;
    for (int c = 0; c < 300 && recv < 16; c++) begin
      if (c < 4) i_out_ready = 1'b1;
      else if (c <= 9) i_out_ready = 1'b0;
      else i_out_ready = 1'($urandom_range(0, 1));
      i_valid = (sent < 16);
      drive(100 + sent, -sent, 10 * sent, 3 * sent, 256, 0, 1'b0, 1'b0);
      #1;
      in_x  = i_valid & o_ready;
      out_x = o_valid & i_out_ready;
      stall = o_valid & ~i_out_ready;
      h0r = o0r;  h0i = o0i;  h1r = o1r;  h1i = o1i;  hrdy = ordy;
      @(posedge i_clk); #1;
      if (in_x) sent++;
      if (out_x) begin
        check4($sformatf("s%0d", recv), h0r, h0i, h1r, h1i,
               100 + 11 * recv, 2 * recv, 100 - 9 * recv, -4 * recv);
        recv++;
      end
      if (stall) begin
        check("stall_ready", hrdy, 0);
        check("stall_valid", ov, 1);
        check4("stall_hold", o0r, o0i, o1r, o1i, h0r, h0i, h1r, h1i);
      end
    end
    check("stream_count", recv, 16);
    i_valid = 1'b0;
    i_out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(posedge i_clk); #1;
      check("stream_no_dup", ov, 0);
    end

    // Two samples in flight, then a one-cycle reset.
    drive(1000, 0, 0, 0, 256, 0, 1'b0, 1'b0);
    i_valid = 1'b1;
    @(posedge i_clk); #1;
    drive(2000, 0, 0, 0, 256, 0, 1'b0, 1'b0);
    @(posedge i_clk); #1;
    i_valid = 1'b0;
    i_rst = 1'b0;
    #1;
    check("mid_rst_valid", ov, 0);
    check("mid_rst_data", o0r, 0);
    @(posedge i_clk); #1;
    check("mid_rst_edge", ov, 0);
    i_rst = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(posedge i_clk); #1;
      check("flushed", ov, 0);
    end
    send_one("post_rst", 5, 0, 0, 0, 256, 0, 1'b0, 1'b0);
    check4("post_rst", o0r, o0i, o1r, o1i, 5, 0, 5, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
